// File: rtl/high_score_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : high_score_tracker_pkg
// Description : Shared definitions for the high-score tracker: game-state
//               encodings driven by the game FSM, the tracker FSM state type,
//               the BCD digit width and the reset value of each score digit.
// Revision    : 1.0 - initial release
// ============================================================================
package high_score_tracker_pkg;

    localparam int BCD_W      = 4;
    localparam int NUM_DIGITS = 6;

    // Encodings of the game state machine output
    localparam logic [1:0] GS_IDLE = 2'b00;
    localparam logic [1:0] GS_WAIT = 2'b01;
    localparam logic [1:0] GS_TIME = 2'b10;
    localparam logic [1:0] GS_DONE = 2'b11;

    localparam logic [BCD_W-1:0] HS_INIT_DIGIT_DEFAULT = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMP    = 2'd1,
        ST_UPDATE = 2'd2
    } hs_state_t;

    typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] score_t;

endpackage : high_score_tracker_pkg
`default_nettype wire

// File: rtl/high_score_tracker_score_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : score_display_mux
// Description : Six 2:1 4-bit muxes choosing between the stored best score
//               and the live count for the BCD encoders.
// Ports       : i_sel_hs - 1 selects the stored score, 0 the live count
//               i_hs     - stored best score digits (digit 0 least significant)
//               i_cur    - live count digits
//               o_disp   - digits forwarded to the encoders
// Revision    : 1.0 - initial release
// ============================================================================
module score_display_mux
    import high_score_tracker_pkg::*;
(
    input  logic   i_sel_hs,
    input  score_t i_hs,
    input  score_t i_cur,
    output score_t o_disp
);

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign o_disp[gi] = i_sel_hs ? i_hs[gi] : i_cur[gi];
    end

endmodule : score_display_mux
`default_nettype wire

// File: rtl/high_score_tracker.sv
`default_nettype none
// ============================================================================
// Module      : high_score_tracker
// Description : Captures the six-digit BCD reaction time when a round ends,
//               compares it digit-serially (most significant first) against
//               the stored best (lowest) time and replaces the best when the
//               new time is strictly lower. Drives the display digits and a
//               timed new-record LED.
// Ports       : clk         - divided game clock (1 kHz)
//               Reset       - asynchronous active-high reset
//               clear_hs    - (HS_CLEAR_EN only) restore 999999 while idle
//               game_state  - game FSM state (00 idle .. 11 done)
//               cur0..cur5  - live BCD count, cur0 least significant
//               disp0..disp5- digits to the BCD encoders
//               hs_busy     - compare in progress
//               new_record  - one-cycle pulse when the best is replaced
//               rec_led     - new-record LED
// Macro       : HS_CLEAR_EN adds the clear_hs input.
// Revision    : 1.0 - initial release
// ============================================================================
module high_score_tracker
    import high_score_tracker_pkg::*;
#(
    parameter int                REC_LED_CYCLES = 2000,
    parameter logic [BCD_W-1:0]  HS_INIT_DIGIT  = HS_INIT_DIGIT_DEFAULT
) (
    input  logic             clk,
    input  logic             Reset,
`ifdef HS_CLEAR_EN
    input  logic             clear_hs,
`endif
    input  logic [1:0]       game_state,
    input  logic [BCD_W-1:0] cur0,
    input  logic [BCD_W-1:0] cur1,
    input  logic [BCD_W-1:0] cur2,
    input  logic [BCD_W-1:0] cur3,
    input  logic [BCD_W-1:0] cur4,
    input  logic [BCD_W-1:0] cur5,
    output logic [BCD_W-1:0] disp0,
    output logic [BCD_W-1:0] disp1,
    output logic [BCD_W-1:0] disp2,
    output logic [BCD_W-1:0] disp3,
    output logic [BCD_W-1:0] disp4,
    output logic [BCD_W-1:0] disp5,
    output logic             hs_busy,
    output logic             new_record,
    output logic             rec_led
);

    localparam int     C_LED_W   = $clog2(REC_LED_CYCLES + 1);
    localparam score_t C_HS_INIT = {NUM_DIGITS{HS_INIT_DIGIT}};

    hs_state_t          r_state;
    hs_state_t          w_next_state;
    logic [1:0]         r_prev_state;
    score_t             r_snap;
    score_t             r_hs;
    logic [2:0]         r_idx;
    logic [C_LED_W-1:0] r_led_cnt;

    score_t             w_cur;
    score_t             w_disp;
    logic               w_end_evt;
    logic               w_clear_req;
    logic               w_capture;
    logic               w_idx_dec;
    logic               w_do_update;
    logic               w_do_clear;
    logic [BCD_W-1:0]   w_snap_digit;
    logic [BCD_W-1:0]   w_hs_digit;

    assign w_cur     = {cur5, cur4, cur3, cur2, cur1, cur0};
    assign w_end_evt = (game_state == GS_DONE) && (r_prev_state != GS_DONE);

`ifdef HS_CLEAR_EN
    assign w_clear_req = clear_hs;
`else
    assign w_clear_req = 1'b0;
`endif

    assign w_snap_digit = r_snap[r_idx];
    assign w_hs_digit   = r_hs[r_idx];

    // ------------------------------------------------------------------
    // Tracker FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_idx_dec    = 1'b0;
        w_do_update  = 1'b0;
        w_do_clear   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A clear in the same cycle as a round end swallows the event
                if (w_clear_req) begin
                    w_do_clear = 1'b1;
                end else if (w_end_evt) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_CMP;
                end
            end
            ST_CMP: begin
                if (w_snap_digit < w_hs_digit) begin
                    w_next_state = ST_UPDATE;
                end else if (w_snap_digit > w_hs_digit) begin
                    w_next_state = ST_IDLE;
                end else if (r_idx == 3'd0) begin
                    // Every digit equal: a tie keeps the old score
                    w_next_state = ST_IDLE;
                end else begin
                    w_idx_dec = 1'b1;
                end
            end
            ST_UPDATE: begin
                w_do_update  = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Snapshot, digit index, stored score and LED timer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_prev_state <= GS_IDLE;
            r_snap       <= '0;
            r_idx        <= 3'd0;
            r_hs         <= C_HS_INIT;
            r_led_cnt    <= '0;
        end else begin
            r_prev_state <= game_state;

            if (w_capture) begin
                r_snap <= w_cur;
                r_idx  <= 3'd5;
            end else if (w_idx_dec) begin
                r_idx <= r_idx - 3'd1;
            end

            if (w_do_update) begin
                r_hs <= r_snap;
            end else if (w_do_clear) begin
                r_hs <= C_HS_INIT;
            end

            if (w_do_update) begin
                r_led_cnt <= C_LED_W'(REC_LED_CYCLES);
            end else if (w_do_clear || (r_led_cnt == '0)) begin
                r_led_cnt <= '0;
            end else begin
                r_led_cnt <= r_led_cnt - C_LED_W'(1);
            end
        end
    end

    assign hs_busy    = (r_state != ST_IDLE);
    assign new_record = (r_state == ST_UPDATE);
    assign rec_led    = (r_led_cnt != '0);

    // ------------------------------------------------------------------
    // Display selection
    // ------------------------------------------------------------------
    score_display_mux u_disp_mux (
        .i_sel_hs (game_state == GS_IDLE),
        .i_hs     (r_hs),
        .i_cur    (w_cur),
        .o_disp   (w_disp)
    );

    assign disp0 = w_disp[0];
    assign disp1 = w_disp[1];
    assign disp2 = w_disp[2];
    assign disp3 = w_disp[3];
    assign disp4 = w_disp[4];
    assign disp5 = w_disp[5];

endmodule : high_score_tracker
`default_nettype wire

// File: tb/tb_high_score_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_high_score_tracker
// Description : Self-checking bench for high_score_tracker. Rounds are
//               played with random and directed end times; a transaction-
//               level model (scores as plain numbers, compare length from
//               the first differing digit) predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_high_score_tracker;

    localparam int          REC        = 2000;
    localparam logic [23:0] INIT_SCORE = 24'h999999;
`ifdef HS_CLEAR_EN
    localparam bit CLR_AVAIL = 1'b1;
`else
    localparam bit CLR_AVAIL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic [1:0] game_state = 2'b00;
    logic [3:0] cur0 = 0, cur1 = 0, cur2 = 0, cur3 = 0, cur4 = 0, cur5 = 0;
    logic [3:0] disp0, disp1, disp2, disp3, disp4, disp5;
    logic       hs_busy, new_record, rec_led;
`ifdef HS_CLEAR_EN
    logic       clear_hs = 1'b0;
`endif

    always #5 clk = ~clk;

    high_score_tracker dut (
        .clk        (clk),
        .Reset      (Reset),
`ifdef HS_CLEAR_EN
        .clear_hs   (clear_hs),
`endif
        .game_state (game_state),
        .cur0       (cur0),
        .cur1       (cur1),
        .cur2       (cur2),
        .cur3       (cur3),
        .cur4       (cur4),
        .cur5       (cur5),
        .disp0      (disp0),
        .disp1      (disp1),
        .disp2      (disp2),
        .disp3      (disp3),
        .disp4      (disp4),
        .disp5      (disp5),
        .hs_busy    (hs_busy),
        .new_record (new_record),
        .rec_led    (rec_led)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [23:0] m_best;
    logic [23:0] m_pend;
    logic [1:0]  m_prev;
    logic        m_upd;
    int          m_j;      // cycles since capture, -1 when idle
    int          m_n;      // number of digit compares for this round
    int          m_led;

    // Observation counters for directed checks
    int cnt_busy, cnt_pulse, cnt_led;

    function automatic logic [23:0] disp_vec();
        return {disp5, disp4, disp3, disp2, disp1, disp0};
    endfunction

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_best = INIT_SCORE;
        m_prev = 2'b00;
        m_j    = -1;
        m_led  = 0;
        m_upd  = 1'b0;
        m_n    = 0;
        m_pend = '0;
    endtask

    task automatic model_edge(input logic [1:0] gs, input logic [23:0] cv, input logic clr);
        logic evt;
        int   k;
        evt    = (gs == 2'b11) && (m_prev != 2'b11);
        m_prev = gs;
        if (m_led > 0) m_led--;
        if (m_j >= 0) begin
            m_j++;
            if (m_j == m_n + int'(m_upd)) begin
                if (m_upd) begin
                    m_best = m_pend;
                    m_led  = REC;
                end
                m_j = -1;
            end
        end else if (clr) begin
            m_best = INIT_SCORE;
            m_led  = 0;
        end else if (evt) begin
            m_pend = cv;
            m_upd  = (cv < m_best);
            k = -1;
            for (int i = 5; i >= 0; i--) begin
                if (k < 0 && cv[4*i +: 4] != m_best[4*i +: 4]) k = i;
            end
            m_n = (k < 0) ? 6 : 6 - k;
            m_j = 0;
        end
    endtask

    task automatic step(input logic [1:0] gs, input logic [23:0] cv, input logic clr);
        game_state = gs;
        {cur5, cur4, cur3, cur2, cur1, cur0} = cv;
`ifdef HS_CLEAR_EN
        clear_hs = clr;
`endif
        @(posedge clk);
        #1;
        model_edge(gs, cv, clr && CLR_AVAIL);
        check("hs_busy",    {23'd0, hs_busy},    {23'd0, (m_j >= 0)});
        check("new_record", {23'd0, new_record}, {23'd0, (m_j >= 0) && m_upd && (m_j == m_n)});
        check("rec_led",    {23'd0, rec_led},    {23'd0, (m_led != 0)});
        check("disp",       disp_vec(),          (gs == 2'b00) ? m_best : cv);
        cnt_busy  += int'(hs_busy);
        cnt_pulse += int'(new_record);
        cnt_led   += int'(rec_led);
    endtask

    function automatic logic [23:0] rand_cur();
        return 24'($urandom);
    endfunction

    function automatic logic rand_clr();
        return ($urandom_range(0, 7) == 0);
    endfunction

    // One game round ending with end_val; cur keeps changing while compare runs
    task automatic round(input logic [23:0] end_val, input bit rnd_clr);
        for (int i = 0; i < 2; i++) step(2'b00, rand_cur(), rnd_clr && rand_clr());
        cnt_busy = 0; cnt_pulse = 0;
        for (int i = 0; i < 2; i++) step(2'b01, rand_cur(), 1'b0);
        for (int i = 0; i < 3; i++) step(2'b10, rand_cur(), 1'b0);
        step(2'b11, end_val, 1'b0);
        for (int i = 0; i < 9; i++) step(2'b11, rand_cur(), rnd_clr && rand_clr());
        step(2'b00, rand_cur(), 1'b0);
    endtask

    function automatic logic [23:0] near_best(input logic [23:0] base);
        logic [23:0] v;
        int k;
        v = base;
        k = $urandom_range(0, 5);
        for (int i = 0; i <= k; i++) begin
            v[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        Reset = 1'b0;
        #1;
        check("reset_disp",  disp_vec(), INIT_SCORE);
        check("reset_busy",  {23'd0, hs_busy},    24'd0);
        check("reset_led",   {23'd0, rec_led},    24'd0);
        check("reset_pulse", {23'd0, new_record}, 24'd0);

        // First record; LED must stay lit for exactly REC cycles
        cnt_led = 0;
        round(24'h000347, 1'b0);
        check("rec347_pulse", 24'(cnt_pulse), 24'd1);
        check("rec347_busy",  24'(cnt_busy),  24'd2);
        check("rec347_hs",    disp_vec(),     24'h000347);
        for (int i = 0; i < REC + 10; i++) step(2'b00, rand_cur(), 1'b0);
        check("rec347_led_len", 24'(cnt_led), 24'(REC));

        round(24'h000512, 1'b0);
        check("r512_busy",  24'(cnt_busy),  24'd4);
        check("r512_pulse", 24'(cnt_pulse), 24'd0);
        check("r512_hs",    disp_vec(),     24'h000347);

        round(24'h000347, 1'b0);
        check("tie_busy",  24'(cnt_busy),  24'd6);
        check("tie_pulse", 24'(cnt_pulse), 24'd0);
        check("tie_hs",    disp_vec(),     24'h000347);

        round(24'h000346, 1'b0);
        check("r346_busy",  24'(cnt_busy),  24'd7);
        check("r346_pulse", 24'(cnt_pulse), 24'd1);
        check("r346_hs",    disp_vec(),     24'h000346);

        for (int r = 0; r < 60; r++) begin
            round(($urandom_range(0, 4) == 0) ? rand_cur() : near_best(m_best), 1'b1);
        end

        // Reset in the middle of a long compare
        round(24'h000100, 1'b0);
        step(2'b10, rand_cur(), 1'b0);
        step(2'b11, 24'h000099, 1'b0);
        step(2'b11, rand_cur(), 1'b0);
        step(2'b11, rand_cur(), 1'b0);
        Reset = 1'b1;
        #2;
        game_state = 2'b00;
        #1;
        check("midrst_disp", disp_vec(), INIT_SCORE);
        check("midrst_busy", {23'd0, hs_busy}, 24'd0);
        check("midrst_led",  {23'd0, rec_led}, 24'd0);
        @(posedge clk);
        #1;
        Reset = 1'b0;
        model_reset();
        step(2'b00, rand_cur(), 1'b0);
        check("post_rst_hs", disp_vec(), INIT_SCORE);
        round(24'h123456, 1'b0);
        check("post_rst_rec", disp_vec(), 24'h123456);

`ifdef HS_CLEAR_EN
        // Clear and round end in the same idle cycle: clear wins
        step(2'b10, rand_cur(), 1'b0);
        step(2'b11, 24'h000001, 1'b1);
        check("clr_busy", {23'd0, hs_busy}, 24'd0);
        check("clr_led",  {23'd0, rec_led}, 24'd0);
        for (int i = 0; i < 8; i++) step(2'b11, rand_cur(), 1'b0);
        step(2'b00, rand_cur(), 1'b0);
        check("clr_hs", disp_vec(), INIT_SCORE);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_high_score_tracker
`default_nettype wire
